// File: rtl/scan_regfile_pkg.sv
// rtl/scan_regfile_pkg.sv - shared types, default geometry and chain length helper for scan_regfile
package scan_regfile_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 8;

    typedef enum logic {
        FUNC = 1'b0,
        SCAN = 1'b1
    } scan_mode_e;

    function automatic int chain_len(input int width, input int depth);
        return width * depth;
    endfunction

endpackage

// File: rtl/scan_regfile_word.sv
// rtl/scan_regfile_word.sv - one scannable register word; serial data enters bit 0 and leaves from bit WIDTH-1
module scan_reg_word
    import scan_regfile_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             Clock,
    input  logic             nReset,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadData,
    input  logic             Shift,
    input  logic             Sin,
    output logic [WIDTH-1:0] Dout,
    output logic             Sout
);

    logic [WIDTH-1:0] word_q;
    logic [WIDTH-1:0] word_d;

    // Shift wins over Load so scan mode can never be disturbed by a functional write.
    always_comb begin
        word_d = word_q;
        if (Shift) begin
            word_d = {word_q[WIDTH-2:0], Sin};
        end else if (Load) begin
            word_d = LoadData;
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            word_q <= '0;
        end else begin
            word_q <= word_d;
        end
    end

    assign Dout = word_q;
    assign Sout = word_q[WIDTH-1];

endmodule

// File: rtl/scan_regfile.sv
// rtl/scan_regfile.sv - DEPTH x WIDTH register bank with one scan chain; SCAN_REGFILE_BYPASS_EN enables write-through reads
module scan_regfile
    import scan_regfile_pkg::*;
#(
    parameter  int WIDTH     = DEF_WIDTH,
    parameter  int DEPTH     = DEF_DEPTH,
    localparam int ADDR_W    = $clog2(DEPTH),
    localparam int CHAIN_LEN = chain_len(WIDTH, DEPTH),
    localparam int CNT_W     = $clog2(CHAIN_LEN)
) (
    input  logic              Clock,
    input  logic              nReset,
    input  logic              RegWe,
    input  logic [ADDR_W-1:0] Rw,
    input  logic [WIDTH-1:0]  Wd,
    input  logic [ADDR_W-1:0] Rs1,
    input  logic [ADDR_W-1:0] Rs2,
    output logic [WIDTH-1:0]  Rd1,
    output logic [WIDTH-1:0]  Rd2,
    input  logic              Test,
    input  logic              SDI,
    output logic              SDO,
    output logic [CNT_W-1:0]  ScanCount,
    output logic              ScanDone
);

    scan_mode_e       mode;
    logic             wr_en;
    logic [DEPTH-1:0] load_vec;
    logic [DEPTH:0]   chain;
    logic [WIDTH-1:0] word_dout [DEPTH];

    assign mode     = Test ? SCAN : FUNC;
    assign wr_en    = RegWe && (mode == FUNC);
    assign chain[0] = SDI;
    assign SDO      = chain[DEPTH];

    // Out-of-range write addresses match no word, so they fall through harmlessly.
    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        assign load_vec[i] = wr_en && (Rw == ADDR_W'(i));

        scan_reg_word #(.WIDTH(WIDTH)) u_word (
            .Clock    (Clock),
            .nReset   (nReset),
            .Load     (load_vec[i]),
            .LoadData (Wd),
            .Shift    (mode == SCAN),
            .Sin      (chain[i]),
            .Dout     (word_dout[i]),
            .Sout     (chain[i+1])
        );
    end

    always_comb begin
        Rd1 = '0;
        Rd2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (Rs1 == ADDR_W'(i)) Rd1 = word_dout[i];
            if (Rs2 == ADDR_W'(i)) Rd2 = word_dout[i];
        end
`ifdef SCAN_REGFILE_BYPASS_EN
        if ((|load_vec) && (Rs1 == Rw)) Rd1 = Wd;
        if ((|load_vec) && (Rs2 == Rw)) Rd2 = Wd;
`endif
    end

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             done_q;
    logic             done_d;

    always_comb begin
        cnt_d  = '0;
        done_d = 1'b0;
        if (mode == SCAN) begin
            if (cnt_q == CNT_W'(CHAIN_LEN - 1)) begin
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign ScanCount = cnt_q;
    assign ScanDone  = done_q;

endmodule

// File: tb/tb_scan_regfile.sv
// tb/tb_scan_regfile.sv - self-checking bench for scan_regfile (8x16 main instance, 6x16 boundary instance)
module tb_scan_regfile;

    logic        Clock;
    logic        nReset;
    logic        RegWe;
    logic [2:0]  Rw;
    logic [15:0] Wd;
    logic [2:0]  Rs1;
    logic [2:0]  Rs2;
    logic [15:0] Rd1;
    logic [15:0] Rd2;
    logic        Test;
    logic        SDI;
    logic        SDO;
    logic [6:0]  ScanCount;
    logic        ScanDone;

    logic        bRegWe;
    logic [2:0]  bRw;
    logic [15:0] bWd;
    logic [2:0]  bRs1;
    logic [2:0]  bRs2;
    logic [15:0] bRd1;
    logic [15:0] bRd2;
    logic        bTest;
    logic        bSDI;
    logic        bSDO;
    logic [6:0]  bCnt;
    logic        bDone;

    int checks = 0;
    int errors = 0;
    bit started = 0;

    scan_regfile #(.WIDTH(16), .DEPTH(8)) dut (
        .Clock(Clock), .nReset(nReset), .RegWe(RegWe), .Rw(Rw), .Wd(Wd),
        .Rs1(Rs1), .Rs2(Rs2), .Rd1(Rd1), .Rd2(Rd2), .Test(Test), .SDI(SDI),
        .SDO(SDO), .ScanCount(ScanCount), .ScanDone(ScanDone)
    );

    scan_regfile #(.WIDTH(16), .DEPTH(6)) dut6 (
        .Clock(Clock), .nReset(nReset), .RegWe(bRegWe), .Rw(bRw), .Wd(bWd),
        .Rs1(bRs1), .Rs2(bRs2), .Rd1(bRd1), .Rd2(bRd2), .Test(bTest), .SDI(bSDI),
        .SDO(bSDO), .ScanCount(bCnt), .ScanDone(bDone)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the whole bank as one 128-bit chain, word r at bits r*16 +: 16,
    // plus the number of edges spent in the current scan pass.
    logic [127:0] m_chain;
    int           m_edges;

    always @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            m_chain <= '0;
            m_edges <= 0;
        end else if (Test) begin
            m_chain <= {m_chain[126:0], SDI};
            m_edges <= m_edges + 1;
        end else begin
            if (RegWe) m_chain[int'(Rw)*16 +: 16] <= Wd;
            m_edges <= 0;
        end
    end

    function automatic logic [15:0] m_read(input logic [2:0] a);
        logic [15:0] v;
        v = m_chain[int'(a)*16 +: 16];
`ifdef SCAN_REGFILE_BYPASS_EN
        if (RegWe && !Test && (a == Rw)) v = Wd;
`endif
        return v;
    endfunction

    always @(negedge Clock) begin
        if (started) begin
            chk("rd1", {16'h0, Rd1}, {16'h0, m_read(Rs1)});
            chk("rd2", {16'h0, Rd2}, {16'h0, m_read(Rs2)});
            chk("sdo", {31'h0, SDO}, {31'h0, m_chain[127]});
            chk("scan_count", {25'h0, ScanCount}, m_edges % 128);
            chk("scan_done", {31'h0, ScanDone},
                {31'h0, (m_edges != 0) && (m_edges % 128 == 0)});
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    int done_cnt;
    int done_edge;
    bit reached;

    initial begin
        nReset = 1'b0; RegWe = 1'b0; Rw = '0; Wd = '0; Rs1 = '0; Rs2 = '0;
        Test = 1'b0; SDI = 1'b0;
        bRegWe = 1'b0; bRw = '0; bWd = '0; bRs1 = '0; bRs2 = '0; bTest = 1'b0; bSDI = 1'b0;

        // Reset state
        tick(); tick();
        started = 1;
        tick();
        chk("reset_cnt", {25'h0, ScanCount}, 0);
        chk("reset_sdo", {31'h0, SDO}, 0);
        nReset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            Rs1 = 3'(i); Rs2 = 3'(7 - i);
            #1 chk("reset_rd1", {16'h0, Rd1}, 0);
            tick();
        end

        // Independent writes, then the A5C3 readback
        for (int i = 0; i < 8; i++) begin
            RegWe = 1'b1; Rw = 3'(i); Wd = 16'(32'h1111 * i);
            tick();
        end
        Rw = 3'd3; Wd = 16'hA5C3;
        tick();
        RegWe = 1'b0; Rs1 = 3'd3; Rs2 = 3'd3;
        #1 chk("wr_rd1_r3", {16'h0, Rd1}, 32'hA5C3);
        chk("wr_rd2_r3", {16'h0, Rd2}, 32'hA5C3);
        for (int i = 0; i < 8; i++) begin
            Rs1 = 3'(i); Rs2 = 3'((i + 3) % 8);
            tick();
        end
        Rs1 = 3'd6;
        #1 chk("wr_rd1_r6", {16'h0, Rd1}, 32'h6666);

        // Same-cycle write visibility
        RegWe = 1'b1; Rw = 3'd5; Wd = 16'h0000;
        tick();
        Wd = 16'h1234; Rs1 = 3'd5;
`ifdef SCAN_REGFILE_BYPASS_EN
        #1 chk("bypass_same_cycle", {16'h0, Rd1}, 32'h1234);
`else
        #1 chk("bypass_same_cycle", {16'h0, Rd1}, 32'h0000);
`endif
        tick();
        RegWe = 1'b0;
        #1 chk("bypass_next_cycle", {16'h0, Rd1}, 32'h1234);

        // Full scan pass with inverting feedback
        RegWe = 1'b1; Rw = 3'd7; Wd = 16'h8001;
        tick();
        Rw = 3'd0; Wd = 16'h0001;
        tick();
        RegWe = 1'b0;
        #1 chk("scan_sdo_first", {31'h0, SDO}, 1);
        Test = 1'b1; SDI = ~SDO;
        done_cnt = 0; done_edge = 0;
        for (int e = 1; e <= 128; e++) begin
            tick();
            if (e == 1) chk("scan_sdo_second", {31'h0, SDO}, 0);
            if (ScanDone) begin done_cnt++; done_edge = e; end
            SDI = ~SDO;
        end
        chk("scan_done_count", done_cnt, 1);
        chk("scan_done_edge", done_edge, 128);
        chk("scan_count_wrap", {25'h0, ScanCount}, 0);
        Test = 1'b0; SDI = 1'b0;
        Rs1 = 3'd7; Rs2 = 3'd0;
        #1 chk("inv_r7", {16'h0, Rd1}, 32'h7FFE);
        chk("inv_r0", {16'h0, Rd2}, 32'hFFFE);
        Rs1 = 3'd3; Rs2 = 3'd1;
        #1 chk("inv_r3", {16'h0, Rd1}, 32'h5A3C);
        chk("inv_r1", {16'h0, Rd2}, 32'hEEEE);
        tick();

        // Test has priority over RegWe
        RegWe = 1'b1; Rw = 3'd2; Wd = 16'h00F0;
        tick();
        Test = 1'b1; Wd = 16'hFFFF; SDI = 1'b0; Rs1 = 3'd2;
        tick();
        chk("test_priority_r2", {16'h0, Rd1}, 32'h01E1);
        Test = 1'b0; RegWe = 1'b0;
        tick();

        // Reset in the middle of a pass
        Test = 1'b1; SDI = 1'b1;
        reached = 0;
        for (int k = 0; k < 200 && !reached; k++) begin
            tick();
            if (ScanCount == 7'd40) reached = 1;
        end
        chk("reach_count_40", {31'h0, reached}, 1);
        nReset = 1'b0;
        #1 chk("midreset_cnt", {25'h0, ScanCount}, 0);
        chk("midreset_done", {31'h0, ScanDone}, 0);
        Rs1 = 3'd0; Rs2 = 3'd7;
        #1 chk("midreset_r0", {16'h0, Rd1}, 0);
        chk("midreset_r7", {16'h0, Rd2}, 0);
        tick();
        nReset = 1'b1;
        done_cnt = 0; done_edge = 0;
        for (int e = 1; e <= 130; e++) begin
            tick();
            if (ScanDone) begin done_cnt++; done_edge = e; end
        end
        chk("resume_done_count", done_cnt, 1);
        chk("resume_done_edge", done_edge, 128);
        Test = 1'b0;
        tick();

        // DEPTH=6 instance: out-of-range addresses and 96-bit chain
        bRegWe = 1'b1; bRw = 3'd7; bWd = 16'hFFFF;
        tick();
        bRw = 3'd5; bWd = 16'hBEEF;
        tick();
        bRegWe = 1'b0; bRs1 = 3'd7; bRs2 = 3'd5;
        #1 chk("d6_rd1_r7", {16'h0, bRd1}, 0);
        chk("d6_rd2_r5", {16'h0, bRd2}, 32'hBEEF);
        bRs1 = 3'd6; bRs2 = 3'd0;
        #1 chk("d6_rd1_r6", {16'h0, bRd1}, 0);
        chk("d6_rd2_r0", {16'h0, bRd2}, 0);
        bTest = 1'b1;
        done_cnt = 0; done_edge = 0;
        for (int e = 1; e <= 100; e++) begin
            tick();
            if (bDone) begin done_cnt++; done_edge = e; end
        end
        chk("d6_done_count", done_cnt, 1);
        chk("d6_done_edge", done_edge, 96);
        bTest = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
